switch_selector: RTL and testbench

- Sequential counterpart to the switch-based selection decode: the selection index is generated by user input instead of being decoded from switch levels.
- Takes raw `next`/`prev` push-buttons and an optional direct load.
- Holds a 3-bit selection index, drives a one-hot 8-bit LED image of it, and pulses a change strobe.
- Sits between the board button pins and the song/voice select logic of the music player top level.

---
 rtl/switch_selector_pkg.sv | 21 ++
 rtl/switch_selector_debouncer.sv | 49 ++++
 rtl/switch_selector.sv | 80 ++++++++
 tb/tb_switch_selector.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/switch_selector_pkg.sv
// Shared constants and helpers for the button-driven selection index.
// Index width, LED image width, reset values and the default debounce length.
package switch_selector_pkg;

   localparam int unsigned SEL_W   = 32'd3;
   localparam int unsigned NUM_SEL = 32'd8;

   localparam logic [SEL_W-1:0]   SEL_RESET_IDX = 3'd0;
   localparam logic [NUM_SEL-1:0] SEL_RESET_LED = 8'b00000001;

   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 32'd50000;

   // One-hot LED image of a selection index
   function automatic logic [NUM_SEL-1:0] sel_onehot(input logic [SEL_W-1:0] idx);
      logic [NUM_SEL-1:0] v;
      v      = {NUM_SEL{1'b0}};
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/switch_selector_debouncer.sv
// button_debouncer: 2-flop synchronizer, stability counter, debounced level
// and a registered one-cycle pulse on each debounced rising edge.
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 32'd50000,
   parameter int unsigned CNT_W           = 32'd16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

   logic             sync1_r;
   logic             sync2_r;
   logic             db_r;
   logic [CNT_W-1:0] cnt_r;
   logic             press_r;

   // Synchronize the raw level, then require a full run of differing samples before flipping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         db_r    <= 1'b0;
         cnt_r   <= CNT_ZERO;
         press_r <= 1'b0;
      end else begin
         sync1_r <= btn;
         sync2_r <= sync1_r;
         press_r <= 1'b0;
         if (sync2_r == db_r) begin
            cnt_r <= CNT_ZERO;
         end else if (cnt_r < CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
         end else begin
            db_r    <= sync2_r;
            cnt_r   <= CNT_ZERO;
            press_r <= sync2_r;
         end
      end
   end

   assign press = press_r;

endmodule

// File: rtl/switch_selector.sv
// Selection index stepped by debounced next/prev buttons or loaded directly,
// with a registered one-hot LED image and a change strobe.
module switch_selector #(
   parameter int unsigned DEBOUNCE_CYCLES = switch_selector_pkg::DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned CNT_W           = 32'd16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_next,
   input  logic       btn_prev,
   input  logic       load_en,
   input  logic [2:0] load_idx,
   output logic [2:0] sel_idx,
   output logic [7:0] led_out,
   output logic       sel_changed
);

   import switch_selector_pkg::*;

   logic             next_pulse_s;
   logic             prev_pulse_s;
   logic [SEL_W-1:0] next_idx_s;
   logic [SEL_W-1:0] sel_idx_r;
   logic [7:0]       led_r;
   logic             changed_r;

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_db_next (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_next),
      .press (next_pulse_s)
   );

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_db_prev (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_prev),
      .press (prev_pulse_s)
   );

   // Next index: load wins and swallows pulses; opposing pulses cancel; steps wrap mod 8
   always_comb begin
      next_idx_s = sel_idx_r;
      if (load_en) begin
         next_idx_s = load_idx;
      end else if (next_pulse_s && prev_pulse_s) begin
         next_idx_s = sel_idx_r;
      end else if (next_pulse_s) begin
         next_idx_s = sel_idx_r + 3'd1;
      end else if (prev_pulse_s) begin
         next_idx_s = sel_idx_r - 3'd1;
      end else begin
         next_idx_s = sel_idx_r;
      end
   end

   // Index, LED image and strobe update together so they never disagree
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel_idx_r <= SEL_RESET_IDX;
         led_r     <= SEL_RESET_LED;
         changed_r <= 1'b0;
      end else begin
         sel_idx_r <= next_idx_s;
         led_r     <= sel_onehot(next_idx_s);
         changed_r <= (next_idx_s != sel_idx_r);
      end
   end

   assign sel_idx     = sel_idx_r;
   assign led_out     = led_r;
   assign sel_changed = changed_r;

endmodule

// File: tb/tb_switch_selector.sv
// Self-checking bench for switch_selector with DEBOUNCE_CYCLES=4: directed table,
// hand-written reset/glitch sequences and random stimulus against a window model.
module tb_switch_selector;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_next, btn_prev, load_en;
   logic [2:0] load_idx;
   logic [2:0] sel_idx;
   logic [7:0] led_out;
   logic       sel_changed;

   int pass_cnt  = 0;
   int total_cnt = 0;

   switch_selector #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
      .load_en(load_en), .load_idx(load_idx),
      .sel_idx(sel_idx), .led_out(led_out), .sel_changed(sel_changed)
   );

   always #5 clk = ~clk;

   // Reference model: raw level history per button; the debounced level flips when the
   // last D samples seen through the 2-cycle synchronizer all differ from it.
   bit       qn[$], qp[$];
   bit       db_n, db_p, pn, pp, m_chg;
   bit [2:0] m_sel;

   function automatic bit window_flips(input bit q[$], input bit db);
      for (int i = 0; i < D; i++) begin
         int k;
         bit v;
         k = q.size() - 3 - i;
         v = (k < 0) ? 1'b0 : q[k];
         if (v == db) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_reset();
      qn.delete(); qp.delete();
      db_n = 0; db_p = 0; pn = 0; pp = 0; m_chg = 0; m_sel = 3'd0;
   endtask

   task automatic model_edge();
      bit [2:0] ns;
      bit fn, fp;
      qn.push_back(btn_next);
      qp.push_back(btn_prev);
      if (load_en)        ns = load_idx;
      else if (pn && pp)  ns = m_sel;
      else if (pn)        ns = 3'((m_sel + 1) % 8);
      else if (pp)        ns = 3'((m_sel + 7) % 8);
      else                ns = m_sel;
      m_chg = (ns != m_sel);
      m_sel = ns;
      fn = window_flips(qn, db_n);
      fp = window_flips(qp, db_p);
      pn = fn && !db_n;
      pp = fp && !db_p;
      if (fn) db_n = !db_n;
      if (fp) db_p = !db_p;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // One clock: advance the model, then compare on the falling edge
   task automatic cycle();
      if (!reset) model_edge();
      @(posedge clk);
      @(negedge clk);
      check("sel_idx", {29'd0, sel_idx}, {29'd0, m_sel});
      check("led_out", {24'd0, led_out}, {24'd0, 8'd1 << m_sel});
      check("sel_changed", {31'd0, sel_changed}, {31'd0, m_chg});
   endtask

   typedef struct {
      bit       n, p, ld;
      bit [2:0] lidx;
      int       cyc;
      bit [2:0] esel;
      bit [7:0] eled;
      int       echg;
   } vec_t;

   vec_t tbl[14];
   int   chg_seen;

   task automatic glitch_seq();
      chg_seen = 0;
      for (int g = 0; g < 5; g++) begin
         btn_next = 1'b1;
         repeat (3) begin cycle(); chg_seen += int'(sel_changed); end
         btn_next = 1'b0;
         repeat (3) begin cycle(); chg_seen += int'(sel_changed); end
      end
      repeat (6) begin cycle(); chg_seen += int'(sel_changed); end
      check("glitch_sel", {29'd0, sel_idx}, 32'd2);
      check("glitch_changes", chg_seen, 32'd0);
   endtask

   initial begin
      reset = 1'b1; btn_next = 1'b0; btn_prev = 1'b0; load_en = 1'b0; load_idx = 3'd0;
      model_reset();
      #1;
      check("reset_sel", {29'd0, sel_idx}, 32'd0);
      check("reset_led", {24'd0, led_out}, 32'h01);
      check("reset_chg", {31'd0, sel_changed}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      //          n  p  ld lidx cyc esel eled          echg
      tbl[0]  = '{0, 0, 0, 3'd0, 20, 3'd0, 8'b00000001, 0};
      tbl[1]  = '{1, 0, 0, 3'd0, 30, 3'd1, 8'b00000010, 1};
      tbl[2]  = '{0, 0, 0, 3'd0, 10, 3'd1, 8'b00000010, 0};
      tbl[3]  = '{1, 0, 0, 3'd0, 10, 3'd2, 8'b00000100, 1};
      tbl[4]  = '{0, 0, 0, 3'd0, 10, 3'd2, 8'b00000100, 0};
      tbl[5]  = '{0, 0, 1, 3'd7,  1, 3'd7, 8'b10000000, 1};
      tbl[6]  = '{0, 0, 0, 3'd0,  2, 3'd7, 8'b10000000, 0};
      tbl[7]  = '{1, 0, 0, 3'd0, 10, 3'd0, 8'b00000001, 1};
      tbl[8]  = '{0, 0, 0, 3'd0, 10, 3'd0, 8'b00000001, 0};
      tbl[9]  = '{0, 1, 0, 3'd0, 10, 3'd7, 8'b10000000, 1};
      tbl[10] = '{0, 0, 0, 3'd0, 10, 3'd7, 8'b10000000, 0};
      tbl[11] = '{1, 1, 0, 3'd0, 12, 3'd7, 8'b10000000, 0};
      tbl[12] = '{0, 0, 0, 3'd0, 10, 3'd7, 8'b10000000, 0};
      tbl[13] = '{0, 0, 1, 3'd7,  1, 3'd7, 8'b10000000, 0};

      for (int i = 0; i < 14; i++) begin
         if (i == 5) glitch_seq();
         btn_next = tbl[i].n; btn_prev = tbl[i].p;
         load_en = tbl[i].ld; load_idx = tbl[i].lidx;
         chg_seen = 0;
         repeat (tbl[i].cyc) begin cycle(); chg_seen += int'(sel_changed); end
         check($sformatf("vec%0d_sel", i), {29'd0, sel_idx}, {29'd0, tbl[i].esel});
         check($sformatf("vec%0d_led", i), {24'd0, led_out}, {24'd0, tbl[i].eled});
         check($sformatf("vec%0d_changes", i), chg_seen, tbl[i].echg);
      end
      load_en = 1'b0;

      // prev held, reset hits two counts into the debounce, button stays held
      btn_prev = 1'b1;
      repeat (4) cycle();
      reset = 1'b1;
      model_reset();
      #1;
      check("rst_mid_sel", {29'd0, sel_idx}, 32'd0);
      check("rst_mid_led", {24'd0, led_out}, 32'h01);
      repeat (2) cycle();
      reset = 1'b0;
      repeat (2 + D) cycle();
      check("rst_before_step", {29'd0, sel_idx}, 32'd0);
      cycle();
      check("rst_step_sel", {29'd0, sel_idx}, 32'd7);
      check("rst_step_led", {24'd0, led_out}, 32'h80);
      check("rst_step_chg", {31'd0, sel_changed}, 32'd1);
      repeat (20) cycle();
      check("rst_hold_sel", {29'd0, sel_idx}, 32'd7);
      btn_prev = 1'b0;
      repeat (10) cycle();

      // random button activity and loads against the window model
      begin
         int rn = 0, rp = 0;
         for (int i = 0; i < 1500; i++) begin
            if (rn == 0) begin btn_next = 1'($urandom_range(0, 1)); rn = $urandom_range(1, 10); end
            if (rp == 0) begin btn_prev = 1'($urandom_range(0, 1)); rp = $urandom_range(1, 10); end
            rn--; rp--;
            load_en  = ($urandom_range(0, 15) == 0);
            load_idx = 3'($urandom_range(0, 7));
            cycle();
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
